// File: rtl/crack_scheduler.sv
// crack_scheduler: sequencer for a farm of NUM_WORKERS brute-force MD5 workers.
// The BCD password range [search_lo, search_hi] is cut into chunks of
// CHUNK_M1_BCD+1 candidates. Each idle worker slot receives the next chunk.
// The first reported match stops the whole farm.
// Optional feature: define CRACK_SCHED_CYCLE_COUNT_EN to build the busy-cycle
// counter on cycle_count. When it is undefined, cycle_count is tied to zero.
module crack_scheduler #(
    parameter int          NUM_WORKERS  = 4,
    parameter logic [31:0] CHUNK_M1_BCD = 32'h0009_9999
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [31:0]              search_lo,
    input  logic [31:0]              search_hi,
    input  logic [127:0]             hash_in,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [31:0]              answer,
    output logic [15:0]              chunks_issued,
    output logic [31:0]              cycle_count,
    output logic [NUM_WORKERS-1:0]   w_rst_n,
    output logic [32*NUM_WORKERS-1:0] w_lower,
    output logic [32*NUM_WORKERS-1:0] w_upper,
    output logic [127:0]             w_hash,
    input  logic [NUM_WORKERS-1:0]   w_done,
    input  logic [NUM_WORKERS-1:0]   w_found,
    input  logic [32*NUM_WORKERS-1:0] w_answer
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    // Eight-digit BCD add with a carry out of digit 7 in bit 32.
    function automatic logic [32:0] bcd_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] res;
        logic [4:0]  dsum;
        logic        carry;
        res   = '0;
        carry = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dsum = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'd0, carry};
            if (dsum > 5'd9) begin
                dsum  = dsum + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            res[4*i+:4] = dsum[3:0];
        end
        res[32] = carry;
        return res;
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic [31:0]            next_lo_q;
    logic [31:0]            hi_q;
    logic                   remaining_q;
    logic [NUM_WORKERS-1:0] active_q;
    logic [1:0]             guard_q [NUM_WORKERS];

    logic                   start_ok;
    logic                   match_any;
    logic [31:0]            match_answer;
    logic [NUM_WORKERS-1:0] fin_vec;
    logic [NUM_WORKERS-1:0] launch_vec;
    logic                   dispatch;
    logic                   slot_taken;
    logic [32:0]            chunk_raw;
    logic [31:0]            chunk_upper;
    logic [32:0]            next_raw;
    logic                   chunk_last;
    logic [NUM_WORKERS-1:0] w_rst_n_d;

    // A start pulse is honoured in every state except while a search runs.
    assign start_ok = start && (state_q != S_RUN);

    // Chunk bounds for the next launch. The upper bound is clamped to hi when
    // the chunk would overrun it or wrap past 99999999.
    assign chunk_raw   = bcd_add(next_lo_q, CHUNK_M1_BCD);
    assign chunk_upper = (chunk_raw[32] || (chunk_raw[31:0] > hi_q)) ? hi_q : chunk_raw[31:0];
    assign next_raw    = bcd_add(chunk_upper, 32'd1);
    assign chunk_last  = (chunk_upper == hi_q) || next_raw[32];

    // Per-slot status after the post-launch guard window. The lowest-index
    // match wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        fin_vec      = '0;
        match_any    = 1'b0;
        match_answer = '0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            if (active_q[k] && (guard_q[k] == 2'd0)) begin
                fin_vec[k] = w_done[k] && !w_found[k];
            end
        end
        for (int k = NUM_WORKERS - 1; k >= 0; k--) begin
            if (active_q[k] && (guard_q[k] == 2'd0) && w_found[k]) begin
                match_any    = 1'b1;
                match_answer = w_answer[32*k+:32];
            end
        end
    end

    // Pick the lowest free slot for at most one launch per cycle. A match or
    // an abort in the same cycle suppresses the launch.
    always_comb begin
        launch_vec = '0;
        slot_taken = 1'b0;
        dispatch   = (state_q == S_RUN) && remaining_q && !abort && !match_any;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            if (dispatch && !active_q[k] && !slot_taken) begin
                launch_vec[k] = 1'b1;
                slot_taken    = 1'b1;
            end
        end
    end

    // Worker resets are held low outside S_RUN and for the single launch
    // cycle of a slot. A slot that has run once stays released until it is
    // relaunched.
    always_comb begin
        w_rst_n_d = '0;
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            for (int k = 0; k < NUM_WORKERS; k++) begin
                w_rst_n_d[k] = !launch_vec[k] && (active_q[k] || w_rst_n[k]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. Abort beats a match, and a match beats exhaustion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) begin
                    state_d = (search_lo > search_hi) ? S_EXHAUSTED : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_EXHAUSTED;
                end else if (match_any) begin
                    state_d = S_FOUND;
                end else if (!remaining_q && (active_q == '0)) begin
                    state_d = S_EXHAUSTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_FOUND) || (state_q == S_EXHAUSTED);
    end

    // Search datapath: range pointer, slot bookkeeping, bounds and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_lo_q     <= '0;
            hi_q          <= '0;
            remaining_q   <= 1'b0;
            active_q      <= '0;
            w_hash        <= '0;
            w_lower       <= '0;
            w_upper       <= '0;
            w_rst_n       <= '0;
            found         <= 1'b0;
            answer        <= '0;
            chunks_issued <= '0;
            // NOTE: the guard array is small control state, so it is reset with everything else.
            for (int k = 0; k < NUM_WORKERS; k++) begin
                guard_q[k] <= 2'd0;
            end
        end else begin
            w_rst_n <= w_rst_n_d;
            if (start_ok) begin
                next_lo_q     <= search_lo;
                hi_q          <= search_hi;
                remaining_q   <= (search_lo <= search_hi);
                w_hash        <= hash_in;
                active_q      <= '0;
                found         <= 1'b0;
                answer        <= '0;
                chunks_issued <= '0;
                for (int k = 0; k < NUM_WORKERS; k++) begin
                    guard_q[k] <= 2'd0;
                end
            end else if (state_q == S_RUN) begin
                active_q <= (active_q & ~fin_vec) | launch_vec;
                if (!abort && match_any) begin
                    found  <= 1'b1;
                    answer <= match_answer;
                end
                for (int k = 0; k < NUM_WORKERS; k++) begin
                    if (launch_vec[k]) begin
                        w_lower[32*k+:32] <= next_lo_q;
                        w_upper[32*k+:32] <= chunk_upper;
                        guard_q[k]        <= 2'd3;
                    end else if (guard_q[k] != 2'd0) begin
                        guard_q[k] <= guard_q[k] - 2'd1;
                    end
                end
                if (launch_vec != '0) begin
                    next_lo_q   <= next_raw[31:0];
                    remaining_q <= !chunk_last;
                    if (chunks_issued != 16'hFFFF) begin
                        chunks_issued <= chunks_issued + 16'd1;
                    end
                end
            end
        end
    end

`ifdef CRACK_SCHED_CYCLE_COUNT_EN
    // Count the cycles spent in S_RUN since the last accepted start, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (start_ok) begin
            cycle_count <= '0;
        end else if ((state_q == S_RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_crack_scheduler.sv
// tb_crack_scheduler: directed bench for crack_scheduler. Each worker is either
// a small behavioural stand-in, which scans its chunk one candidate per cycle
// and matches on w_hash[31:0], or a set of levels forced by the bench.
module tb_crack_scheduler;

    localparam int          NW    = 4;
    localparam logic [31:0] CHUNK = 32'h99;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [31:0]       search_lo;
    logic [31:0]       search_hi;
    logic [127:0]      hash_in;
    logic              busy;
    logic              done;
    logic              found;
    logic [31:0]       answer;
    logic [15:0]       chunks_issued;
    logic [31:0]       cycle_count;
    logic [NW-1:0]     w_rst_n;
    logic [32*NW-1:0]  w_lower;
    logic [32*NW-1:0]  w_upper;
    logic [127:0]      w_hash;
    logic [NW-1:0]     w_done;
    logic [NW-1:0]     w_found;
    logic [32*NW-1:0]  w_answer;

    logic              use_model;
    logic [NW-1:0]     f_done;
    logic [NW-1:0]     f_found;
    logic [32*NW-1:0]  f_answer;
    logic [NW-1:0]     m_done;
    logic [NW-1:0]     m_found;
    logic [32*NW-1:0]  m_answer;
    logic [31:0]       m_cur [NW];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          slot;
        logic [31:0] lo;
        logic [31:0] hi;
    } launch_t;

    launch_t     launches[$];
    logic [15:0] prev_ci = 16'd0;
    bit          seen [NW];
    logic [31:0] seen_lo [NW];
    int          busy_cycles = 0;

    crack_scheduler #(.NUM_WORKERS(NW), .CHUNK_M1_BCD(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .search_lo(search_lo), .search_hi(search_hi), .hash_in(hash_in),
        .busy(busy), .done(done), .found(found), .answer(answer),
        .chunks_issued(chunks_issued), .cycle_count(cycle_count),
        .w_rst_n(w_rst_n), .w_lower(w_lower), .w_upper(w_upper), .w_hash(w_hash),
        .w_done(w_done), .w_found(w_found), .w_answer(w_answer)
    );

    always #5 clk = ~clk;

    assign w_done   = use_model ? m_done   : f_done;
    assign w_found  = use_model ? m_found  : f_found;
    assign w_answer = use_model ? m_answer : f_answer;

    // Decimal increment via integer conversion.
    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        int          n;
        logic [31:0] r;
        n = 0;
        for (int i = 7; i >= 0; i--) n = n * 10 + int'(v[4*i+:4]);
        n = n + 1;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i+:4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Behavioural workers: restart from w_lower while held in reset.
    always @(posedge clk) begin
        for (int k = 0; k < NW; k++) begin
            if (!w_rst_n[k]) begin
                m_cur[k]   <= w_lower[32*k+:32];
                m_done[k]  <= 1'b0;
                m_found[k] <= 1'b0;
            end else if (!m_done[k]) begin
                if (m_cur[k] == w_hash[31:0]) begin
                    m_found[k]           <= 1'b1;
                    m_done[k]            <= 1'b1;
                    m_answer[32*k+:32]   <= m_cur[k];
                end else if (m_cur[k] == w_upper[32*k+:32]) begin
                    m_done[k] <= 1'b1;
                end else begin
                    m_cur[k] <= bcd_inc(m_cur[k]);
                end
            end
        end
    end

    // Launch log and busy-cycle tally, sampled on the falling edge.
    always @(negedge clk) begin
        if (start && !busy) busy_cycles = 0;
        if (busy) busy_cycles++;
        if (chunks_issued < prev_ci) begin
            launches.delete();
            for (int k = 0; k < NW; k++) seen[k] = 1'b0;
        end else if (chunks_issued != prev_ci) begin
            launch_t l;
            l.slot = -1; l.lo = '0; l.hi = '0;
            for (int k = 0; k < NW; k++) begin
                if (l.slot < 0 && !w_rst_n[k] && (!seen[k] || seen_lo[k] != w_lower[32*k+:32])) begin
                    l.slot = k; l.lo = w_lower[32*k+:32]; l.hi = w_upper[32*k+:32];
                    seen[k] = 1'b1; seen_lo[k] = l.lo;
                end
            end
            launches.push_back(l);
        end
        prev_ci = chunks_issued;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] lo, input logic [31:0] hi, input logic [127:0] h);
        @(posedge clk); #1;
        search_lo = lo; search_hi = hi; hash_in = h; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {127'd0, done}, 128'd1);
    endtask

    task automatic check_cycles(input string tag);
`ifdef CRACK_SCHED_CYCLE_COUNT_EN
        check(tag, {96'd0, cycle_count}, 128'(busy_cycles));
`else
        check(tag, {96'd0, cycle_count}, 128'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        search_lo = '0; search_hi = '0; hash_in = '0;
        use_model = 1'b1; f_done = '0; f_found = '0; f_answer = '0;
        m_done = '0; m_found = '0; m_answer = '0;
        for (int k = 0; k < NW; k++) begin seen[k] = 1'b0; seen_lo[k] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_found", {127'd0, found}, 128'd0);
        check("rst_chunks", {112'd0, chunks_issued}, 128'd0);
        check("rst_wrstn", {124'd0, w_rst_n}, 128'd0);
        check("rst_bounds", {w_lower, w_upper}, 128'd0 | 256'd0);
        check("rst_hash", w_hash, 128'd0);
        rst = 1'b0;

        // Match on 00000512 with the behavioural workers.
        do_start(32'h0, 32'h999, {96'd0, 32'h0000_0512});
        check("t1_busy", {127'd0, busy}, 128'd1);
        check("t1_hash", w_hash, {96'd0, 32'h0000_0512});
        @(posedge clk); #1;
        check("t1_c1_chunks", {112'd0, chunks_issued}, 128'd1);
        check("t1_c1_wrstn", {124'd0, w_rst_n}, 128'h0);
        check("t1_c1_bounds0", {96'd0, w_lower[31:0], w_upper[31:0]}, {96'd0, 32'h0, 32'h99});
        @(posedge clk); #1;
        check("t1_c2_wrstn", {124'd0, w_rst_n}, 128'h1);
        wait_done(5000, "t1_timeout");
        check("t1_found", {127'd0, found}, 128'd1);
        check("t1_answer", {96'd0, answer}, {96'd0, 32'h0000_0512});
        check("t1_busy_low", {127'd0, busy}, 128'd0);
        check("t1_wrstn_off", {124'd0, w_rst_n}, 128'd0);
        check("t1_nlaunch", {127'd0, launches.size() >= 5}, 128'd1);
        for (int i = 0; i < 5 && i < launches.size(); i++) begin
            logic [31:0] elo;
            logic [31:0] ehi;
            elo = 32'(i) << 8;
            ehi = elo | 32'h99;
            if (i < 4) check($sformatf("t1_slot%0d", i), 128'(launches[i].slot), 128'(i));
            check($sformatf("t1_lo%0d", i), {96'd0, launches[i].lo}, {96'd0, elo});
            check($sformatf("t1_hi%0d", i), {96'd0, launches[i].hi}, {96'd0, ehi});
        end
        check_cycles("t1_cycles");

        // No match: full exhaustion of 000..999.
        do_start(32'h0, 32'h999, {96'd0, 32'hFFFF_FFFF});
        wait_done(5000, "t2_timeout");
        check("t2_found", {127'd0, found}, 128'd0);
        check("t2_chunks", {112'd0, chunks_issued}, 128'd10);
        check("t2_nlaunch", 128'(launches.size()), 128'd10);
        if (launches.size() > 0)
            check("t2_last_hi", {96'd0, launches[launches.size()-1].hi}, {96'd0, 32'h999});
        check_cycles("t2_cycles");

        // Range narrower than one chunk.
        do_start(32'h150, 32'h160, {96'd0, 32'hFFFF_FFFF});
        wait_done(500, "t3_timeout");
        check("t3_chunks", {112'd0, chunks_issued}, 128'd1);
        if (launches.size() > 0)
            check("t3_bounds", {64'd0, launches[0].lo, launches[0].hi}, {64'd0, 32'h150, 32'h160});
        check("t3_found", {127'd0, found}, 128'd0);

        // Top of the BCD space: clamp, no wrap to zero.
        do_start(32'h9999_9950, 32'h9999_9999, {96'd0, 32'hFFFF_FFFF});
        wait_done(500, "t4_timeout");
        check("t4_chunks", {112'd0, chunks_issued}, 128'd1);
        if (launches.size() > 0)
            check("t4_bounds", {64'd0, launches[0].lo, launches[0].hi}, {64'd0, 32'h9999_9950, 32'h9999_9999});

        // Empty range goes straight to exhaustion.
        do_start(32'h500, 32'h100, 128'd0);
        check("t4b_done", {127'd0, done}, 128'd1);
        check("t4b_chunks", {112'd0, chunks_issued}, 128'd0);

        // Forced status: guard window, start while busy, simultaneous matches.
        use_model = 1'b0;
        do_start(32'h0, 32'h999, 128'd0);
        @(posedge clk); #1;
        f_done[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        f_done[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_chunks", {112'd0, chunks_issued}, 128'd4);
        check("t5_slot0_lo", {96'd0, w_lower[31:0]}, 128'd0);
        search_lo = 32'h700; hash_in = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_ignored_start", {112'd0, chunks_issued}, 128'd4);
        check("t5_hash_kept", w_hash, 128'd0);
        f_answer = {32'h33, 32'h22, 32'h11, 32'h00};
        f_found  = 4'b1010;
        @(posedge clk); #1;
        f_found = '0;
        check("t5_found", {127'd0, found}, 128'd1);
        check("t5_answer", {96'd0, answer}, 128'h11);
        check("t5_done", {127'd0, done}, 128'd1);
        check("t5_wrstn_off", {124'd0, w_rst_n}, 128'd0);

        // Abort outranks a same-cycle match.
        do_start(32'h0, 32'h999, 128'd0);
        repeat (8) @(posedge clk);
        #1;
        f_answer[31:0] = 32'h77; f_found = 4'b0001; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; f_found = '0;
        check("t6_done", {127'd0, done}, 128'd1);
        check("t6_found", {127'd0, found}, 128'd0);
        check("t6_answer", {96'd0, answer}, 128'd0);

        // Reset in the middle of a search.
        use_model = 1'b1;
        do_start(32'h0, 32'h999, {96'd0, 32'hFFFF_FFFF});
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7_busy", {127'd0, busy}, 128'd0);
        check("t7_done", {127'd0, done}, 128'd0);
        check("t7_chunks", {112'd0, chunks_issued}, 128'd0);
        check("t7_wrstn", {124'd0, w_rst_n}, 128'd0);
        check("t7_lower", w_lower, 128'd0);
        check("t7_hash", w_hash, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
